// File: rtl/rtlola_event_feeder.sv
// Timestamped event source driving an RTLola monitor's x/newX inputs.
// Define FEEDER_LATE_DROP_EN to discard late events instead of issuing them.
module rtlola_event_feeder #(
    parameter int DATA_W      = 64,
    parameter int TS_W        = 32,
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int TICK_DIV    = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [TS_W-1:0]   push_ts,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] x,
    output logic              newX,
    output logic [TS_W-1:0]   time_now,
    output logic              busy,
    output logic              late
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        GAP
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt, cnt_nxt;
    logic [PW-1:0]     presc;
    logic [TS_W-1:0]   ts_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push_fire;
    logic              eval, pop, issue, late_set;
    logic              head_due, head_late;
    logic [TS_W-1:0]   head_ts;
    logic [DATA_W-1:0] head_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign push_ready = !full && en && !rst;
    assign push_fire  = push_valid && push_ready;

    assign head_ts   = ts_mem[rd_ptr[AW-1:0]];
    assign head_data = data_mem[rd_ptr[AW-1:0]];
    assign head_due  = !empty && (head_ts <= time_now);
    assign head_late = !empty && (head_ts < time_now);

    assign newX = (state == HOLD);
    assign busy = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push_fire) begin
            ts_mem[wr_ptr[AW-1:0]]   <= push_ts;
            data_mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // The last GAP cycle doubles as a WAIT compare so back-to-back
    // events keep exactly HOLD_CYCLES low cycles between pulses.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        eval      = 1'b0;
        pop       = 1'b0;
        issue     = 1'b0;
        late_set  = 1'b0;
        if (en) begin
            unique case (state)
                IDLE: begin
                    if (!empty)
                        state_nxt = WAIT;
                end
                WAIT: begin
                    eval = 1'b1;
                    if (empty)
                        state_nxt = IDLE;
                end
                HOLD: begin
                    if (cnt == CNT_MAX) begin
                        state_nxt = GAP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == CNT_MAX) begin
                        cnt_nxt   = '0;
                        eval      = 1'b1;
                        state_nxt = empty ? IDLE : WAIT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (eval && head_due) begin
                pop      = 1'b1;
                late_set = head_late;
`ifdef FEEDER_LATE_DROP_EN
                if (!head_late) begin
                    issue     = 1'b1;
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
`else
                issue     = 1'b1;
                state_nxt = HOLD;
                cnt_nxt   = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            presc    <= '0;
            time_now <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            x        <= '0;
            late     <= 1'b0;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (en) begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    if (time_now != '1)
                        time_now <= time_now + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (issue)
                    x <= head_data;
                if (late_set)
                    late <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rtlola_event_feeder.md
# rtlola_event_feeder

Synthesizable input-side driver for a generated RTLola monitor `topEntity`. Buffers timestamped input events, keeps a local time base, and presents each event to the monitor's `x`/`newX` pair when its timestamp is reached. `newX` is held for the multi-cycle window the monitor needs, because the monitor's LLC/HLC pipeline runs at 1/4 of the clock rate. It replaces hand-written `#delay` stimulus with a reusable hardware source for on-chip and FPGA runs.

## Interface

Parameters:
- `DATA_W`, 64: width of event value `x`; signed.
- `TS_W`, 32: timestamp and time-base width, unsigned.
- `DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `HOLD_CYCLES`, 4: cycles `newX` is high per event; equals the monitor clock divisor.
- `TICK_DIV`, 100: clock cycles per time unit; 100 gives 1 µs at 100 MHz.

Ports:
- `clk` in 1: single clock, 100 MHz nominal.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable, shared with the monitor's `en`.
- `push_valid` in 1: producer offers an event.
- `push_ready` out 1: FIFO can accept an event.
- `push_ts` in `TS_W`: event timestamp in time units.
- `push_data` in `DATA_W`: event value.
- `x` out `DATA_W`: value to the monitor's `x`.
- `newX` out 1: event strobe to the monitor's `newX`.
- `time_now` out `TS_W`: current local time.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `late` out 1: sticky flag, set when an event timestamp is below `time_now` at issue.

## Operation

- **Push handshake.** An event is accepted on a rising edge with `push_valid && push_ready`. `push_ready = !full && en && !rst`, combinational. Data must hold while valid and not ready.
- **Time base.** A prescaler counts enabled cycles 0..`TICK_DIV`-1. `time_now` increments on wrap. `time_now` saturates at all-ones and never wraps.
- **FSM states:**
  - IDLE: FIFO empty. Go to WAIT when non-empty.
  - WAIT: compare head `ts` ≤ `time_now`. When true, pop the head, load `x`, set `newX`, go to HOLD.
  - HOLD: `newX`=1 for exactly `HOLD_CYCLES` cycles, then go to GAP.
  - GAP: `newX`=0 for `HOLD_CYCLES` cycles, then WAIT if non-empty, else IDLE.
- `x` keeps its last value after `newX` falls; it changes only on issue.
- Events with equal timestamps issue in FIFO order. Each gets its own HOLD+GAP.
- Late event (head `ts` < `time_now` when compared in WAIT): `late` sets and stays set until `rst`. Issue behaviour is set by the Configuration macro.
- **`en`=0:** prescaler, `time_now`, FSM, and the HOLD/GAP counters freeze. `newX` and `x` hold. No push is accepted.
- **`rst`:** FIFO empties, FSM goes to IDLE, and all counters clear, effective at the next edge even mid-HOLD.

## Timing

- Reset values: `x`=0, `newX`=0, `time_now`=0, `busy`=0, `late`=0. `push_ready`=0 while `rst`=1 and 1 on the first cycle after reset (given `en`=1).
- A pushed entry is visible at the FIFO head one cycle after acceptance.
- Issue latency: `newX` rises on the edge after the WAIT compare becomes true. From an empty FIFO, an already-due event gives push → `newX` high in 3 cycles (IDLE→WAIT→HOLD).
- A simultaneous push and pop when full is not allowed; full means not ready.
- Minimum event spacing is 2×`HOLD_CYCLES` cycles.

## Configuration

- `FEEDER_LATE_DROP_EN` defined: a late head event is popped and discarded with no `newX` pulse. `late` sets. The FSM goes to GAP for 0 cycles, i.e. it re-evaluates the next head on the following cycle.
- Not defined: a late event issues immediately like an on-time one. `late` still sets.

## Test plan

Defaults, except `DEPTH`=4.

1. Hold `rst` for 3 cycles, then release → all outputs 0 during reset; `push_ready`=1 on the first post-reset cycle; `time_now`=1 after 100 cycles.
2. Push (ts=100, data=1) at time 0 → `newX` high for exactly 4 cycles, starting 1 cycle after `time_now` becomes 100. `x`=1 and stays 1 afterward.
3. Push (5, 7) and then (5, −3) → two 4-cycle `newX` pulses separated by exactly 4 low cycles. `x`=7 during the first pulse, −3 during the second.
4. Push 4 far-future events → `push_ready`=0. A 5th event with `push_valid` held is accepted on the cycle after the first pop. Order is preserved.
5. Run to `time_now`=10, then push (2, 9) → `late`=1.
   - Without the macro: a 4-cycle pulse with `x`=9.
   - With the macro: no pulse, FIFO empty, `x` unchanged.
6. Drop `en` for 10 cycles mid-HOLD → `newX` stays 1, `time_now` frozen, remaining HOLD cycles complete after `en` returns. Then assert `rst` mid-HOLD → `newX`=0 and `busy`=0 next cycle.
